// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, FSM encoding and helpers for the pipeline stage register.
package pipe_stage_reg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 16;
    localparam int STALL_W    = 16;

    // Every bit of a bubble's control bundle is this value (all zeros).
    localparam logic BUBBLE_BIT = 1'b0;

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == STALL_MAX) ? v : v + {{(STALL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One pipeline slot: valid + ctrl + data. Reset zeroes everything; clear
// makes a bubble (valid/ctrl zero, data kept); load captures a new instruction.
module pipe_stage_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              load,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid <= 1'b0;
            ctrl  <= {CTRL_W{BUBBLE_BIT}};
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= {CTRL_W{BUBBLE_BIT}};
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and stall counter.
// Latency: one cycle from input transfer to out_valid when empty.
// Backpressure: single entry with in_ready = !out_valid || out_ready; with
// PIPE_STAGE_SKID_EN a two-entry skid buffer with registered in_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [STALL_W-1:0] stall_count
);

    logic              in_fire;
    logic              out_fire;
    logic              m_load;
    logic              m_clear;
    logic [CTRL_W-1:0] m_src_ctrl;
    logic [DATA_W-1:0] m_src_data;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (m_clear),
        .load    (m_load),
        .in_ctrl (m_src_ctrl),
        .in_data (m_src_data),
        .valid   (out_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    skid_state_t       state;
    skid_state_t       state_nxt;
    logic              in_ready_q;
    logic              s_load;
    logic              s_clear;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (s_clear),
        .load    (s_load),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (s_valid),
        .ctrl    (s_ctrl),
        .data    (s_data)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_SKID);
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) state_nxt = ST_FULL;
                ST_FULL: begin
                    if (in_fire && !out_ready)
                        state_nxt = ST_SKID;
                    else if (!in_fire && out_ready)
                        state_nxt = ST_EMPTY;
                end
                ST_SKID:  if (out_ready) state_nxt = ST_FULL;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        m_load     = 1'b0;
        m_clear    = 1'b0;
        s_load     = 1'b0;
        s_clear    = 1'b0;
        // Main refills from the skid slot whenever it is occupied.
        m_src_ctrl = s_valid ? s_ctrl : in_ctrl;
        m_src_data = s_valid ? s_data : in_data;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: m_load = in_fire;
                ST_FULL: begin
                    if (in_fire && out_ready)
                        m_load = 1'b1;
                    else if (in_fire)
                        s_load = 1'b1;
                    else if (out_ready)
                        m_clear = 1'b1;
                end
                ST_SKID: begin
                    if (out_ready) begin
                        m_load  = 1'b1;
                        s_clear = 1'b1;
                    end
                end
                default: begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
`else
    assign in_ready   = !out_valid || out_ready;
    assign m_src_ctrl = in_ctrl;
    assign m_src_data = in_data;
    assign m_load     = in_fire && !flush;
    assign m_clear    = flush || (out_fire && !in_fire);
`endif

    always_ff @(posedge Clk) begin
        if (Reset)
            stall_count <= '0;
        else if (out_valid && !out_ready)
            stall_count <= sat_inc(stall_count);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg with a scoreboard of accepted
// instructions; checks ordering, bubble ctrl, stall hold and stall counter.
module tb_pipe_stage_reg;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [31:0] out_data;
    logic [15:0] stall_count;

    typedef struct packed {
        logic [15:0] c;
        logic [31:0] d;
    } ent_t;

    ent_t        sb[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          n_out = 0;
    logic [31:0] last_out = '0;
    logic [15:0] exp_stall = '0;
    logic        last_in_fire = 1'b0;
    int          n_acc;
    int          seq;
    int          cyc;

    pipe_stage_reg dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_data    (out_data),
        .stall_count (stall_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Samples handshakes just before the edge, updates the scoreboard and
    // stall model, then checks registered outputs just after the edge.
    task automatic tick();
        logic        in_f, out_f, stl, hold_chk;
        logic [15:0] pc;
        logic [31:0] pd;
        ent_t        e;
        #1;
        in_f  = in_valid && in_ready;
        out_f = out_valid && out_ready;
        stl   = out_valid && !out_ready;
        if (Reset) begin
            sb.delete();
            exp_stall = '0;
        end else begin
            if (stl && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (flush) begin
                sb.delete();
            end else begin
                if (out_f) begin
                    n_vec++;
                    assert (sb.size() > 0) else begin
                        n_fail++;
                        $error("FAIL sb_underflow: got output %0h expected none", out_data);
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("sb_ctrl", 64'(out_ctrl), 64'(e.c));
                        check("sb_data", 64'(out_data), 64'(e.d));
                        n_out++;
                        last_out = out_data;
                    end
                end
                if (in_f) sb.push_back({in_ctrl, in_data});
            end
        end
        hold_chk     = stl && !flush && !Reset;
        pc           = out_ctrl;
        pd           = out_data;
        last_in_fire = in_f && !flush && !Reset;
        @(posedge Clk);
        #1;
        check("stall_model", 64'(stall_count), 64'(exp_stall));
        if (hold_chk) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ctrl", 64'(out_ctrl), 64'(pc));
            check("hold_data", 64'(out_data), 64'(pd));
        end
        if (!out_valid) check("bubble_ctrl", 64'(out_ctrl), 64'd0);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) tick();
        check("drain_empty", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0;
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single transfer, one-cycle latency.
        in_valid = 1'b1; in_data = 32'h0040_0008; in_ctrl = 16'h00A5; out_ready = 1'b1;
        tick();
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_data", 64'(out_data), 64'h0040_0008);
        check("lat_ctrl", 64'(out_ctrl), 64'h00A5);
        drain();
        check("bubble_data_held", 64'(out_data), 64'h0040_0008);

        // Five stalled cycles with upstream still offering.
        in_valid = 1'b1; in_data = 32'h1111_0001; in_ctrl = 16'h0101; out_ready = 1'b1;
        tick();
        in_data = 32'h2222_0002; in_ctrl = 16'h0202; out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_in_fire) n_acc++;
        end
        check("stall5_count", 64'(stall_count), 64'd5);
        check("stall5_data", 64'(out_data), 64'h1111_0001);
        check("stall5_ctrl", 64'(out_ctrl), 64'h0101);
        check("stall5_in_ready", 64'(in_ready), 64'd0);
`ifdef PIPE_STAGE_SKID_EN
        check("stall5_accepted", 64'(n_acc), 64'd1);
`else
        check("stall5_accepted", 64'(n_acc), 64'd0);
`endif
        drain();
        check("stall5_sb_empty", 64'(sb.size()), 64'd0);

        // Flush with a held entry and a new input offered.
        in_valid = 1'b1; in_data = 32'hAAAA_0001; in_ctrl = 16'h0AA1; out_ready = 1'b1;
        tick();
        in_data = 32'hBBBB_0002; in_ctrl = 16'h0BB2; out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        n_out = 0;
        for (int i = 0; i < 4; i++) tick();
        check("flush_no_output", 64'(n_out), 64'd0);

        // Random handshakes, sequence 1..100.
        n_out = 0; seq = 1; cyc = 0;
        while (n_out < 100 && cyc < 3000) begin
            in_valid  = (seq <= 100) && ($urandom_range(0, 3) != 0);
            in_data   = 32'(seq);
            in_ctrl   = 16'h8000 | 16'(seq);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_in_fire) seq++;
            cyc++;
        end
        check("rand_count", 64'(n_out), 64'd100);
        check("rand_last", 64'(last_out), 64'd100);
        check("rand_sb_empty", 64'(sb.size()), 64'd0);
        drain();

        // Reset and flush together while stalled (SKID state in skid build).
        in_valid = 1'b1; in_data = 32'hCCCC_0001; in_ctrl = 16'h0CC1; out_ready = 1'b1;
        tick();
        in_data = 32'hDDDD_0002; in_ctrl = 16'h0DD2; out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0; Reset = 1'b1; flush = 1'b1;
        tick();
        Reset = 1'b0; flush = 1'b0;
        #1;
        check("rf_stall", 64'(stall_count), 64'd0);
        check("rf_valid", 64'(out_valid), 64'd0);
        check("rf_ctrl", 64'(out_ctrl), 64'd0);
        check("rf_data", 64'(out_data), 64'd0);
        check("rf_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        n_out = 0;
        for (int i = 0; i < 3; i++) tick();
        check("rf_no_output", 64'(n_out), 64'd0);

        // Long stall: counter saturates and never wraps.
        in_valid = 1'b1; in_data = 32'hEEEE_0001; in_ctrl = 16'h0EE1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        check("sat_count", 64'(stall_count), 64'hFFFF);
        check("sat_data", 64'(out_data), 64'hEEEE_0001);
        drain();
        check("sat_after_release", 64'(stall_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
